// File: rtl/multicycle_control_if.sv
// Control bundle between multicycle_control (master) and the MIPS-subset datapath (slave).
interface multicycle_control_if #(
    parameter int unsigned STATE_W = 4
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               zero;
    logic               pc_en;
    logic               ir_write;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [2:0]         alu_op;
    logic [1:0]         pc_source;
    logic               instr_done;
    logic               illegal;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, funct, zero,
        output pc_en, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle FSM controller for the 8-bit MIPS-subset datapath.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: illegal instructions trap into HALT until reset.
module multicycle_control #(
    parameter int unsigned STATE_W = 4
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_control_if.master bus
);
    localparam logic [STATE_W-1:0] FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] MEM_ADDR = STATE_W'(2);
    localparam logic [STATE_W-1:0] MEM_RD   = STATE_W'(3);
    localparam logic [STATE_W-1:0] MEM_WB   = STATE_W'(4);
    localparam logic [STATE_W-1:0] MEM_WR   = STATE_W'(5);
    localparam logic [STATE_W-1:0] EXEC_R   = STATE_W'(6);
    localparam logic [STATE_W-1:0] R_WB     = STATE_W'(7);
    localparam logic [STATE_W-1:0] BRANCH   = STATE_W'(8);
    localparam logic [STATE_W-1:0] JUMP     = STATE_W'(9);
    localparam logic [STATE_W-1:0] EXEC_I   = STATE_W'(10);
    localparam logic [STATE_W-1:0] I_WB     = STATE_W'(11);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam logic [STATE_W-1:0] HALT     = STATE_W'(12);
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;

    logic [STATE_W-1:0] state_q, state_d;
    logic [2:0]         r_alu_op;
    logic               legal;

    always_comb begin
        r_alu_op = 3'b000;
        case (bus.funct)
            F_SUB:   r_alu_op = 3'b001;
            F_AND:   r_alu_op = 3'b010;
            F_OR:    r_alu_op = 3'b011;
            default: r_alu_op = 3'b000;
        endcase
    end

    always_comb begin
        legal = 1'b0;
        case (bus.opcode)
            OP_RTYPE: legal = (bus.funct == F_ADD) || (bus.funct == F_SUB) ||
                              (bus.funct == F_AND) || (bus.funct == F_OR);
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = FETCH;
        bus.pc_en      = 1'b0;
        bus.ir_write   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 3'b000;
        bus.pc_source  = 2'b00;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;

        case (state_q)
            FETCH: begin
                bus.ir_write  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.pc_en     = 1'b1;
                state_d       = DECODE;
            end
            DECODE: begin
                bus.alu_src_b = 2'b10;
                bus.illegal   = !legal;
                if (!legal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    state_d = HALT;
`else
                    state_d = FETCH;
`endif
                end else begin
                    case (bus.opcode)
                        OP_RTYPE:     state_d = EXEC_R;
                        OP_ADDI:      state_d = EXEC_I;
                        OP_LW, OP_SW: state_d = MEM_ADDR;
                        OP_BEQ:       state_d = BRANCH;
                        default:      state_d = JUMP;
                    endcase
                end
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                bus.mem_read = 1'b1;
                state_d      = MEM_WB;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            MEM_WR: begin
                bus.mem_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = r_alu_op;
                state_d       = R_WB;
            end
            R_WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.alu_op     = r_alu_op;
                bus.instr_done = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_op     = 3'b111;
                bus.pc_source  = 2'b01;
                bus.pc_en      = bus.zero;
                bus.instr_done = 1'b1;
            end
            JUMP: begin
                bus.pc_source  = 2'b10;
                bus.pc_en      = 1'b1;
                bus.instr_done = 1'b1;
            end
            EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                state_d       = I_WB;
            end
            I_WB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            HALT: state_d = HALT;
`endif
            default: state_d = FETCH;
        endcase

        // Reset silences every output immediately, not just from the next edge.
        if (reset) begin
            state_d        = FETCH;
            bus.pc_en      = 1'b0;
            bus.ir_write   = 1'b0;
            bus.mem_read   = 1'b0;
            bus.mem_write  = 1'b0;
            bus.reg_write  = 1'b0;
            bus.reg_dst    = 1'b0;
            bus.mem_to_reg = 1'b0;
            bus.alu_src_a  = 1'b0;
            bus.alu_src_b  = 2'b00;
            bus.alu_op     = 3'b000;
            bus.pc_source  = 2'b00;
            bus.instr_done = 1'b0;
            bus.illegal    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed and random instruction streams checked against a per-class step model.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_control_if #(.STATE_W(4)) bus ();
    multicycle_control #(.STATE_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned fails  = 0;

    // Classes: 0 R-type, 1 addi, 2 lw, 3 sw, 4 beq, 5 j, 6 illegal.
    localparam int PATH [7][5] = '{'{0, 1, 6, 7, 0}, '{0, 1, 10, 11, 0}, '{0, 1, 2, 3, 4},
                                   '{0, 1, 2, 5, 0}, '{0, 1, 8, 0, 0}, '{0, 1, 9, 0, 0},
                                   '{0, 1, 0, 0, 0}};
    localparam int PLEN [7] = '{4, 4, 5, 4, 3, 3, 2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] outs();
        return {bus.pc_en, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write,
                bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_source, bus.instr_done, bus.illegal};
    endfunction

    function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: return (fn == 6'b100000 || fn == 6'b100010 ||
                               fn == 6'b100100 || fn == 6'b100101) ? 0 : 6;
            6'b001000: return 1;
            6'b100011: return 2;
            6'b101011: return 3;
            6'b000100: return 4;
            6'b000010: return 5;
            default:   return 6;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'd0;
            6'b100010: return 3'd1;
            6'b100100: return 3'd2;
            default:   return 3'd3;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_comb_outs", 32'(outs()), 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_outs", 32'(outs()), 0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // nsteps < 0 runs the whole instruction; otherwise stops after nsteps cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int nsteps);
        int c;
        int len;
        int n;
        c   = cls_of(op, fn);
        len = PLEN[c];
        n   = (nsteps < 0) ? len : nsteps;
        for (int i = 0; i < n; i++) begin
            logic last;
            logic [1:0] exp_b;
            logic [2:0] exp_op;
            logic [1:0] exp_src;
            last = (i == len - 1);
            @(negedge clk);
            if (i == 0) begin
                bus.opcode = op;
                bus.funct  = fn;
                bus.zero   = z;
            end
            #1;
            exp_b   = (i == 0) ? 2'd1 : (i == 1) ? 2'd2 :
                      (i == 2 && (c == 1 || c == 2 || c == 3)) ? 2'd2 : 2'd0;
            exp_op  = (c == 4 && last) ? 3'd7 : (c == 0 && i >= 2) ? r_alu(fn) : 3'd0;
            exp_src = (c == 4 && last) ? 2'd1 : (c == 5 && last) ? 2'd2 : 2'd0;
            chk("state",      32'(bus.state),      PATH[c][i]);
            chk("instr_done", 32'(bus.instr_done), 32'(last && c != 6));
            chk("illegal",    32'(bus.illegal),    32'(c == 6 && i == 1));
            chk("ir_write",   32'(bus.ir_write),   32'(i == 0));
            chk("pc_en",      32'(bus.pc_en),
                32'(i == 0 || (last && c == 5) || (last && c == 4 && z)));
            chk("pc_source",  32'(bus.pc_source),  32'(exp_src));
            chk("reg_write",  32'(bus.reg_write),  32'(last && (c == 0 || c == 1 || c == 2)));
            chk("reg_dst",    32'(bus.reg_dst),    32'(last && c == 0));
            chk("mem_to_reg", 32'(bus.mem_to_reg), 32'(last && c == 2));
            chk("mem_read",   32'(bus.mem_read),   32'(c == 2 && i == 3));
            chk("mem_write",  32'(bus.mem_write),  32'(c == 3 && i == 3));
            chk("alu_src_a",  32'(bus.alu_src_a),  32'(i == 2 && c != 5));
            chk("alu_src_b",  32'(bus.alu_src_b),  32'(exp_b));
            chk("alu_op",     32'(bus.alu_op),     32'(exp_op));
        end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        if (c == 6 && n == len) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                #1;
                chk("halt_state", 32'(bus.state), 12);
                chk("halt_outs", 32'(outs()), 0);
            end
            do_reset();
        end
`endif
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        bus.opcode = 6'd0;
        bus.funct  = 6'd0;
        bus.zero   = 1'b0;
        reset      = 1'b1;
        do_reset();

        run_instr(6'b000000, 6'b100000, 1'b0, -1);
        run_instr(6'b000000, 6'b100010, 1'b0, -1);
        run_instr(6'b000000, 6'b100100, 1'b0, -1);
        run_instr(6'b000000, 6'b100101, 1'b0, -1);
        run_instr(6'b100011, 6'b000000, 1'b0, -1);
        run_instr(6'b101011, 6'b000000, 1'b0, -1);
        run_instr(6'b000100, 6'b000000, 1'b1, -1);
        run_instr(6'b000100, 6'b000000, 1'b0, -1);
        run_instr(6'b000010, 6'b000000, 1'b1, -1);
        run_instr(6'b001000, 6'b000000, 1'b0, -1);
        run_instr(6'b111111, 6'b000000, 1'b0, -1);
        run_instr(6'b000000, 6'b000111, 1'b0, -1);

        // Abandon an R-type in EXEC_R, then hold reset across two edges.
        run_instr(6'b000000, 6'b100000, 1'b0, 3);
        do_reset();

        for (int r = 0; r < 40; r++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 9))
                0: begin op = 6'b000000; fn = 6'b100000; end
                1: begin op = 6'b000000; fn = 6'b100010; end
                2: begin op = 6'b000000; fn = 6'b100100; end
                3: begin op = 6'b000000; fn = 6'b100101; end
                4: op = 6'b001000;
                5: op = 6'b100011;
                6: op = 6'b101011;
                7: op = 6'b000100;
                8: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)), -1);
        end
        run_instr(6'b001000, 6'b000000, 1'b0, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Finite-state controller that sequences the 8-bit-data / 32-bit-instruction MIPS-subset datapath over multiple clock cycles. It replaces single-cycle decode, so one shared ALU and one memory port serve fetch, address and execute steps. It sits beside the datapath and drives every enable and mux select: PC, instruction register, register file, data memory, ALU. Its inputs are the instruction register opcode/funct fields and the ALU zero flag.

## Interface
- `STATE_W`, 4: width of the state register and the `state` debug output.
- `clk`  in  1  single system clock; all state changes occur on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clk` rising edge.
- `opcode`  in  6  instruction register bits [31:26].
- `funct`  in  6  instruction register bits [5:0].
- `zero`  in  1  ALU zero flag; valid combinationally in BRANCH.
- `pc_en`  out  1  PC load enable.
- `ir_write`  out  1  instruction register load.
- `mem_read`  out  1  data memory read enable.
- `mem_write`  out  1  data memory write enable.
- `reg_write`  out  1  register file write enable.
- `reg_dst`  out  1  write address select: 0 = rt [20:16], 1 = rd [15:11].
- `mem_to_reg`  out  1  write data select: 0 = ALUOut, 1 = MDR.
- `alu_src_a`  out  1  ALU input A: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU input B: 00 = register B, 01 = constant 1, 10 = imm[7:0].
- `alu_op`  out  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 111 beq-compare.
- `pc_source`  out  2  PC input: 00 = ALU result, 01 = ALUOut, 10 = jump target imm[25:0].
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction.
- `illegal`  out  1  one-cycle pulse in DECODE on an unsupported opcode or funct.
- `state`  out  STATE_W  current state encoding, for debug.

## Operation
- Supported instructions:
  - R-type: opcode 000000 with funct 100000 add, 100010 sub, 100100 and, 100101 or.
  - addi: 001000.
  - lw: 100011.
  - sw: 101011.
  - beq: 000100.
  - j: 000010.
- States and encodings:
  - FETCH(0): mem/IR fetch. `ir_write`=1, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=000, `pc_source`=00, `pc_en`=1, so PC ← PC+1 (word addressed).
  - DECODE(1): `alu_src_a`=0, `alu_src_b`=10, `alu_op`=000, so ALUOut ← PC+1+imm as the branch target. Dispatch on opcode.
  - MEM_ADDR(2): `alu_src_a`=1, `alu_src_b`=10, add. Goes to MEM_RD for lw, MEM_WR for sw.
  - MEM_RD(3): `mem_read`=1. Goes to MEM_WB.
  - MEM_WB(4): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, `instr_done`=1. Goes to FETCH.
  - MEM_WR(5): `mem_write`=1, `instr_done`=1. Goes to FETCH.
  - EXEC_R(6): `alu_src_a`=1, `alu_src_b`=00, `alu_op` from funct. Goes to R_WB.
  - R_WB(7): `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1, `alu_op` held. Goes to FETCH.
  - BRANCH(8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=111, `pc_source`=01, `pc_en`=`zero`, `instr_done`=1. Goes to FETCH.
  - JUMP(9): `pc_source`=10, `pc_en`=1, `instr_done`=1. Goes to FETCH.
  - EXEC_I(10): `alu_src_a`=1, `alu_src_b`=10, add. Goes to I_WB.
  - I_WB(11): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1, `alu_op` held. Goes to FETCH.
  - HALT(12): only present with the trap macro (see Configuration).
- Unlisted state encodings (13-15) go to FETCH on the next edge with all enables 0.
- All outputs not listed for a state are 0.
- Outputs are combinational decodes of the state register and the `opcode`/`funct` inputs.
- `pc_en` in BRANCH is the only output that depends on `zero`.

## Timing
- Reset:
  - While `reset`=1 at an edge, the next state is FETCH.
  - While `reset` is high, every enable (`pc_en`, `ir_write`, `mem_read`, `mem_write`, `reg_write`) is forced to 0 combinationally.
  - All other outputs are 0 during reset; `state`=0 after the first reset edge.
- Reset mid-instruction abandons the instruction with no write; fetch restarts at PC 0.
- Cycles per instruction, counted from FETCH to the `instr_done` state inclusive:
  - lw: 5.
  - R-type, addi, sw: 4.
  - beq, j: 3.
- `instr_done` is high in exactly one cycle per retired instruction.
- The opcode/funct fields must be stable from the edge ending FETCH; the IR holds them until the next FETCH.
- beq not taken: `pc_en`=0 in BRANCH, so PC keeps the value PC+1 written in FETCH.

## Configuration
- Macro: `MC_CTRL_ILLEGAL_TRAP_EN`.
- Defined:
  - An illegal opcode or funct in DECODE moves to HALT.
  - HALT holds all enables at 0, `state`=12, and is left only by `reset`.
  - `illegal` pulses once, in DECODE.
- Undefined:
  - HALT does not exist.
  - An illegal instruction goes DECODE → FETCH as a NOP; `illegal` pulses for one cycle and `instr_done` does not pulse.

## Test plan
- Reset: hold `reset` for 2 edges mid-EXEC_R → `state`=0, all enables 0 during reset. First FETCH after release has `ir_write`=1 and `pc_en`=1.
- R-type sequence: opcode 000000 with funct 100000 / 100010 / 100100 / 100101 → states 0,1,6,7 with `alu_op` 000 / 001 / 010 / 011. `reg_write`=1 and `reg_dst`=1 only in state 7. 4 cycles each, one `instr_done` pulse each.
- Memory: lw (100011) → states 0,1,2,3,4, `mem_read` only in 3, `mem_to_reg`=1 in 4. sw (101011) → states 0,1,2,5, `mem_write` only in 5, `reg_write` never asserted.
- Branch: beq with `zero`=1 → `pc_en`=1 with `pc_source`=01 in state 8. `zero`=0 → `pc_en`=0. j → `pc_en`=1 with `pc_source`=10 in state 9; each takes 3 cycles.
- Illegal: opcode 111111, and separately opcode 000000 with funct 000111 → `illegal` pulse in DECODE. With the macro: `state` stays 12 for 10 cycles, then reset recovers. Without it: next state 0, no `instr_done` pulse.
